ifetch_axi_rd_slave: RTL and testbench
======================================

// Module: ifetch_axi_rd_slave
// PURPOSE
//  AXI4 read-only responder serving instruction fetch (ICache line refills) from
//  an on-chip word array. Answering end of the IFU/ICache mem_r read channel:
//  accepts AR, waits a fixed latency, returns INCR/WRAP/FIXED bursts on R.
//  Used in NPC simulation builds and as the fetch-side model in unit benches.
// PARAMETERS
//  DEPTH_W   12            log2 of array depth in 32-bit words (4096 words)
//  BASE      32'h80000000  byte address of word 0
//  LATENCY   2             cycles from AR handshake to first rvalid (>=1)
//  ID_W      4             AXI ID width
// PORTS
//  clock     in   1        clock
//  reset     in   1        synchronous, active-high reset
//  arvalid   in   1        read address valid
//  arready   out  1        read address ready
//  araddr    in   32       burst start byte address
//  arid      in   ID_W     transaction ID
//  arlen     in   8        beats-1
//  arsize    in   3        bytes/beat, log2; only 3'b010 legal
//  arburst   in   2        00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  rvalid    out  1        read data valid
//  rready    in   1        read data ready
//  rdata     out  32       read data
//  rresp     out  2        00 OKAY, 10 SLVERR, 11 DECERR
//  rlast     out  1        final beat of burst
//  rid       out  ID_W     echo of arid
//  ld_en     in   1        preload write enable (bench/loader only)
//  ld_addr   in   DEPTH_W  preload word index
//  ld_data   in   32       preload word
// BEHAVIOUR
//  Reset: state IDLE, arready=1, rvalid=0, rlast=0, rresp=00, rdata=0, rid=0.
//   Array contents not cleared by reset.
//  FSM IDLE -> WAIT -> SEND -> IDLE; one outstanding burst only.
//  IDLE: arready=1. arvalid&arready latches addr, id, len, size, burst; beat
//   counter=0; latency counter=LATENCY-1; -> WAIT. arready=0 outside IDLE.
//  WAIT: counter decrements each cycle; at 0 -> SEND with beat 0 registered, so
//   first rvalid appears exactly LATENCY cycles after the AR handshake edge.
//  SEND: rvalid=1; rdata/rresp/rlast/rid stable while rvalid&~rready.
//   On rvalid&rready: if rlast -> IDLE (rvalid=0 next cycle, arready=1);
//   else next beat presented the following cycle (back-to-back, no bubble).
//  Address step per beat: INCR +4; FIXED +0; WRAP +4 with wrap inside
//   aligned window of (arlen+1)*4 bytes: addr = (addr & ~mask) | ((addr+4)&mask),
//   mask=(arlen+1)*4-1. araddr[1:0] ignored (word-aligned reads).
//  Word index = (addr-BASE)>>2, 32-bit subtraction; in range iff addr>=BASE and
//   index < 2**DEPTH_W. Range checked per beat: out-of-range beat -> rresp=11,
//   rdata=0; burst continues to full length.
//  Illegal request (arsize!=010, arburst==11, WRAP with arlen not in {1,3,7,15})
//   -> every beat rresp=10, rdata=0, still arlen+1 beats with correct rlast.
//  rlast=1 iff beat counter == latched arlen. Beat counter 8 bits, no overflow
//   (max 256 beats).
//  Preload: ld_en writes ld_data at ld_addr at clock edge; same-cycle read of
//   same word during SEND returns old data (read-before-write).
//  Reset asserted mid-WAIT or mid-SEND aborts burst: rvalid=0 next cycle,
//   no further beats, IDLE.
// TESTING
//  1 preload words 0..3=A0..A3; AR addr 0x80000000 len 3 INCR, rready=1 ->
//    rvalid at AR+2 cycles, beats A0,A1,A2,A3, rlast on 4th, rresp=00.
//  2 AR addr 0x80000008 len 3 WRAP -> beats word2,3,0,1; rid echoes arid=5.
//  3 same as 1 with rready toggling 1,0,0,1,... -> each beat held stable while
//    stalled, no beat lost or duplicated, arready=0 until final handshake.
//  4 AR addr 0x80003FFC len 1 INCR (DEPTH_W=12) -> beat0 OKAY last word,
//    beat1 rresp=11 rdata=0 rlast=1; AR addr 0x7FFFFFFC -> DECERR.
//  5 arsize=001 len 1 -> 2 beats rresp=10; WRAP len 2 -> 3 beats rresp=10.
//  6 reset asserted after 2nd beat of 8-beat burst -> rvalid=0 next cycle,
//    arready=1; a fresh burst then completes normally.

Source files
------------

// File: rtl/ifetch_axi_rd_slave_if.sv
// AXI4 read-only channel bundle (AR + R) between the fetch-side master and the
// word-array responder.
interface ifetch_axi_rd_slave_if #(
    parameter int ID_W = 4
);
    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ifetch_axi_rd_slave.sv
// AXI4 read responder for instruction fetch: first rvalid LATENCY cycles after AR,
// one burst outstanding, each beat held stable until rready, arready low while busy.
module ifetch_axi_rd_slave #(
    parameter int          DEPTH_W = 12,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2,
    parameter int          ID_W    = 4
) (
    input  logic               clock,
    input  logic               reset,
    ifetch_axi_rd_slave_if.slave axi,
    input  logic               ld_en,
    input  logic [DEPTH_W-1:0] ld_addr,
    input  logic [31:0]        ld_data
);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_ar_fire;
    logic               w_load;
    logic               w_done;

    logic [31:0]        r_mem [2**DEPTH_W];

    logic [31:0]        r_addr;
    logic [31:0]        r_mask;
    logic [ID_W-1:0]    r_id;
    logic [7:0]         r_len;
    logic [7:0]         r_beat;
    logic [1:0]         r_burst;
    logic               r_illegal;
    logic [LAT_W-1:0]   r_lat;

    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;
    logic               r_rlast;
    logic [ID_W-1:0]    r_rid;

    logic [31:0]        w_next_addr;
    logic [31:0]        w_beat_addr;
    logic [7:0]         w_beat_idx;
    logic [31:0]        w_word_off;
    logic               w_in_range;
    logic [DEPTH_W-1:0] w_index;
    logic               w_ar_illegal;
    logic               w_wrap_len_ok;

    assign axi.arready = (r_state == S_IDLE);
    assign axi.rvalid  = r_rvalid;
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = r_rresp;
    assign axi.rlast   = r_rlast;
    assign axi.rid     = r_rid;

    assign w_wrap_len_ok = (axi.arlen == 8'd1) || (axi.arlen == 8'd3) ||
                           (axi.arlen == 8'd7) || (axi.arlen == 8'd15);
    assign w_ar_illegal  = (axi.arsize != 3'b010) || (axi.arburst == 2'b11) ||
                           ((axi.arburst == 2'b10) && !w_wrap_len_ok);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ar_fire   = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (axi.arvalid) begin
                    w_ar_fire   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat == '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (r_rvalid && axi.rready) begin
                    if (r_rlast) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_load      = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wrap keeps the upper bits of the window and advances only the low bits under the mask.
    always_comb begin
        w_next_addr = r_addr + 32'd4;
        case (r_burst)
            2'b00:   w_next_addr = r_addr;
            2'b10:   w_next_addr = (r_addr & ~r_mask) | ((r_addr + 32'd4) & r_mask);
            default: w_next_addr = r_addr + 32'd4;
        endcase
    end

    assign w_beat_addr = (r_state == S_WAIT) ? r_addr : w_next_addr;
    assign w_beat_idx  = (r_state == S_WAIT) ? 8'd0 : (r_beat + 8'd1);
    assign w_word_off  = (w_beat_addr - BASE) >> 2;
    assign w_in_range  = (w_beat_addr >= BASE) && (w_word_off < (32'd1 << DEPTH_W));
    assign w_index     = w_word_off[DEPTH_W-1:0];

    always_ff @(posedge clock) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr    <= '0;
            r_mask    <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_burst   <= '0;
            r_illegal <= 1'b0;
            r_lat     <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
        end else begin
            if (w_ar_fire) begin
                r_addr    <= axi.araddr & 32'hFFFF_FFFC;
                r_mask    <= ((32'(axi.arlen) + 32'd1) << 2) - 32'd1;
                r_id      <= axi.arid;
                r_len     <= axi.arlen;
                r_beat    <= 8'd0;
                r_burst   <= axi.arburst;
                r_illegal <= w_ar_illegal;
                r_lat     <= LAT_W'(LATENCY - 1);
            end
            if ((r_state == S_WAIT) && (r_lat != '0)) begin
                r_lat <= r_lat - 1'b1;
            end
            if (w_load) begin
                r_addr   <= w_beat_addr;
                r_beat   <= w_beat_idx;
                r_rvalid <= 1'b1;
                r_rlast  <= (w_beat_idx == r_len);
                r_rid    <= r_id;
                if (r_illegal) begin
                    r_rresp <= 2'b10;
                    r_rdata <= '0;
                end else if (!w_in_range) begin
                    r_rresp <= 2'b11;
                    r_rdata <= '0;
                end else begin
                    r_rresp <= 2'b00;
                    r_rdata <= r_mem[w_index];
                end
            end
            if (w_done) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_axi_rd_slave.sv
// Directed bench for the fetch-side AXI read responder with an expected-beat queue.
module tb_ifetch_axi_rd_slave;
    localparam int          DEPTH_W = 12;
    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int          LATENCY = 2;
    localparam int          ID_W    = 4;

    typedef struct packed {
        logic [31:0]     data;
        logic [1:0]      resp;
        logic            last;
        logic [ID_W-1:0] id;
    } beat_t;

    logic               clock = 1'b0;
    logic               reset;
    logic               ld_en;
    logic [DEPTH_W-1:0] ld_addr;
    logic [31:0]        ld_data;

    int    checks = 0;
    int    errors = 0;
    logic [31:0] tb_mem [2**DEPTH_W];
    beat_t q[$];

    always #5 clock = ~clock;

    ifetch_axi_rd_slave_if #(.ID_W(ID_W)) bus ();

    ifetch_axi_rd_slave #(
        .DEPTH_W (DEPTH_W),
        .BASE    (BASE),
        .LATENCY (LATENCY),
        .ID_W    (ID_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .axi     (bus),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clock);
        ld_en   = 1'b1;
        ld_addr = idx[DEPTH_W-1:0];
        ld_data = d;
        tb_mem[idx] = d;
        @(negedge clock);
        ld_en   = 1'b0;
    endtask

    // Reference beat list built from the burst definition, independent of the RTL's stepping.
    function automatic void expect_burst(input logic [31:0] addr, input logic [ID_W-1:0] id,
                                         input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
        logic [31:0] aw, a, wsz, base;
        logic        ill;
        beat_t       b;
        ill  = (size != 3'b010) || (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        aw   = addr & 32'hFFFF_FFFC;
        wsz  = (32'(len) + 32'd1) * 32'd4;
        base = aw - (aw % wsz);
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                2'b00:   a = aw;
                2'b10:   a = base + ((aw - base + 32'(4 * i)) % wsz);
                default: a = aw + 32'(4 * i);
            endcase
            b.id   = id;
            b.last = (i == int'(len));
            if (ill) begin
                b.data = '0;
                b.resp = 2'b10;
            end else if (a < BASE || ((a - BASE) >> 2) >= (32'd1 << DEPTH_W)) begin
                b.data = '0;
                b.resp = 2'b11;
            end else begin
                b.data = tb_mem[int'((a - BASE) >> 2)];
                b.resp = 2'b00;
            end
            q.push_back(b);
        end
    endfunction

    task automatic send_ar(input logic [31:0] addr, input logic [ID_W-1:0] id,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int cyc;
        expect_burst(addr, id, len, size, burst);
        @(negedge clock);
        bus.rready  = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arid    = id;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        chk("arready_idle", 32'(bus.arready), 32'd1);
        @(posedge clock);
        #1 bus.arvalid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clock);
            if (bus.rvalid) break;
            @(posedge clock);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(LATENCY));
    endtask

    // mode 0: rready always high; mode 1: rready pattern 1,0,0,1 repeating.
    task automatic run_r(input int mode, input int max_pops);
        int k    = 0;
        int pops = 0;
        bit done = 1'b0;
        while (!done && k < 300) begin
            @(negedge clock);
            bus.rready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            if (bus.rvalid && q.size() > 0) begin
                chk("arready_busy", 32'(bus.arready), 32'd0);
                chk("rdata", bus.rdata, q[0].data);
                chk("rresp", 32'(bus.rresp), 32'(q[0].resp));
                chk("rlast", 32'(bus.rlast), 32'(q[0].last));
                chk("rid",   32'(bus.rid),   32'(q[0].id));
                if (bus.rready) begin
                    void'(q.pop_front());
                    pops++;
                    if (pops == max_pops || q.size() == 0) done = 1'b1;
                end
            end
            k++;
        end
        if (!done) begin
            chk("r_timeout_pending", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic end_chk();
        @(posedge clock);
        @(negedge clock);
        bus.rready = 1'b0;
        chk("rvalid_after_last", 32'(bus.rvalid), 32'd0);
        chk("arready_after_last", 32'(bus.arready), 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        bus.arvalid = 1'b0;
        bus.araddr  = '0;
        bus.arid    = '0;
        bus.arlen   = '0;
        bus.arsize  = 3'b010;
        bus.arburst = 2'b01;
        bus.rready  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_arready", 32'(bus.arready), 32'd1);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_rlast",   32'(bus.rlast),   32'd0);
        chk("rst_rresp",   32'(bus.rresp),   32'd0);
        chk("rst_rdata",   bus.rdata,        32'd0);
        chk("rst_rid",     32'(bus.rid),     32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) preload(i, 32'hA0C0_0000 + 32'(i * 32'h1111));
        preload(4095, 32'h5A5A_F00D);

        // INCR from word 0, continuous rready
        send_ar(32'h8000_0000, 4'd1, 8'd3, 3'b010, 2'b01);
        run_r(0, 1000);
        end_chk();

        // WRAP starting mid-window, id echo
        send_ar(32'h8000_0008, 4'd5, 8'd3, 3'b010, 2'b10);
        run_r(0, 1000);
        end_chk();

        // INCR with stalls
        send_ar(32'h8000_0000, 4'd3, 8'd3, 3'b010, 2'b01);
        run_r(1, 1000);
        end_chk();

        // FIXED repeats one word
        send_ar(32'h8000_0004, 4'd2, 8'd2, 3'b010, 2'b00);
        run_r(0, 1000);
        end_chk();

        // Top of array then past it; below BASE
        send_ar(32'h8000_3FFC, 4'd9, 8'd1, 3'b010, 2'b01);
        run_r(0, 1000);
        end_chk();
        send_ar(32'h7FFF_FFFC, 4'd4, 8'd0, 3'b010, 2'b01);
        run_r(0, 1000);
        end_chk();

        // Illegal size and illegal wrap length
        send_ar(32'h8000_0000, 4'd6, 8'd1, 3'b001, 2'b01);
        run_r(0, 1000);
        end_chk();
        send_ar(32'h8000_0000, 4'd8, 8'd2, 3'b010, 2'b10);
        run_r(0, 1000);
        end_chk();

        // Reset after the 2nd beat of an 8-beat burst
        send_ar(32'h8000_0000, 4'd7, 8'd7, 3'b010, 2'b01);
        run_r(0, 2);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("abort_rvalid",  32'(bus.rvalid),  32'd0);
        chk("abort_arready", 32'(bus.arready), 32'd1);
        reset      = 1'b0;
        bus.rready = 1'b0;
        q.delete();
        repeat (3) begin
            @(negedge clock);
            chk("abort_no_beats", 32'(bus.rvalid), 32'd0);
        end

        send_ar(32'h8000_0010, 4'd10, 8'd3, 3'b010, 2'b01);
        run_r(0, 1000);
        end_chk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
